// File: rtl/move_sequencer.sv
// move_sequencer
//
// Command-side initiator for the per-face stepper drivers. Face-turn commands
// from the solver are buffered in a small FIFO and issued strictly one at a
// time. An issue is a single-cycle one-hot start pulse plus a step count and a
// direction bit. The sequencer then waits for the addressed driver's done to
// fall (acknowledge) and rise again (move finished). A fixed idle gap follows
// before the next command is popped.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   move_valid   command present on move_face / move_turn
//   move_ready   FIFO can accept a command (low while reset is high)
//   move_face    target motor index, 0..NUM_MOTORS-1 legal
//   move_turn    00 no-op, 01 CW 90, 10 180, 11 CCW 90
//   start_out    one-hot, single-cycle start pulse to the addressed driver
//   steps_out    step count of the most recently issued move
//   dir_out      per-motor direction, 1 = CW; only the addressed bit changes
//   done_in      per-driver done
//   busy         FIFO non-empty or sequencer not idle
//   queue_count  current FIFO occupancy
//   error        sticky fault: illegal face or missing acknowledge
module move_sequencer #(
  parameter int NUM_MOTORS  = 6,
  parameter int QUEUE_DEPTH = 16,
  parameter int STEPS_90    = 50,
  parameter int STEPS_180   = 100,
  parameter int ACK_TIMEOUT = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           move_valid,
  output logic                           move_ready,
  input  logic [2:0]                     move_face,
  input  logic [1:0]                     move_turn,
  output logic [NUM_MOTORS-1:0]          start_out,
  output logic [7:0]                     steps_out,
  output logic [NUM_MOTORS-1:0]          dir_out,
  input  logic [NUM_MOTORS-1:0]          done_in,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           error
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int QCNT_W  = PTR_W + 1;
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] TURN_NOP    = 2'b00;
  localparam logic [1:0] TURN_180    = 2'b10;
  localparam logic [1:0] TURN_CCW_90 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_GAP
  } state_t;

  // ------------------------------------------------------------------
  // Helper functions
  // ------------------------------------------------------------------
  function automatic logic [NUM_MOTORS-1:0] face_onehot(input logic [2:0] f);
    logic [NUM_MOTORS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (f == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic face_legal(input logic [2:0] f);
    return int'(f) < NUM_MOTORS;
  endfunction

  function automatic logic [7:0] turn_steps(input logic [1:0] t);
    return (t == TURN_180) ? 8'(STEPS_180) : 8'(STEPS_90);
  endfunction

  // Both the quarter CW turn and the half turn run clockwise.
  function automatic logic turn_is_cw(input logic [1:0] t);
    return t != TURN_CCW_90;
  endfunction

  // ------------------------------------------------------------------
  // Command FIFO
  // ------------------------------------------------------------------
  logic [4:0]        fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [QCNT_W-1:0] count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full        = (count == QCNT_W'(QUEUE_DEPTH));
  assign empty       = (count == '0);
  // Ready is gated by reset so nothing is accepted while the FIFO is flushed.
  assign move_ready  = !reset && !full;
  assign push        = move_valid && move_ready;
  assign queue_count = count;

  // Storage holds data only and is never reset; occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {move_face, move_turn};
  end

  // Pointers wrap naturally because QUEUE_DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + QCNT_W'(1);
        2'b01:   count <= count - QCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  logic [4:0]            head;
  logic [2:0]            head_face;
  logic [1:0]            head_turn;
  logic [NUM_MOTORS-1:0] head_oh;

  assign head      = fifo_mem[rd_ptr];
  assign head_face = head[4:2];
  assign head_turn = head[1:0];
  assign head_oh   = face_onehot(head_face);

  // ------------------------------------------------------------------
  // Sequencer FSM
  // ------------------------------------------------------------------
  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [2:0]            face_q;
  logic [2:0]            face_nxt;
  logic [NUM_MOTORS-1:0] start_nxt;
  logic [7:0]            steps_nxt;
  logic [NUM_MOTORS-1:0] dir_nxt;
  logic                  error_nxt;
  logic                  done_sel;

  // Only the addressed driver's done is observed; the others are masked off.
  assign done_sel = |(done_in & face_onehot(face_q));

  assign busy = !empty || (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      start_out <= '0;
      steps_out <= '0;
      dir_out   <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      start_out <= start_nxt;
      steps_out <= steps_nxt;
      dir_out   <= dir_nxt;
      error     <= error_nxt;
    end
  end

  // The latched face only qualifies done_in after an issue, so it needs no reset.
  always_ff @(posedge clock) begin
    face_q <= face_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    face_nxt  = face_q;
    start_nxt = '0;
    steps_nxt = steps_out;
    dir_nxt   = dir_out;
    error_nxt = error;
    pop       = 1'b0;

    case (state)
      S_IDLE: begin
        if (!empty) begin
          // Every popped entry is consumed; illegal and no-op entries are
          // dropped without leaving IDLE.
          pop = 1'b1;
          if (!face_legal(head_face)) begin
            error_nxt = 1'b1;
          end else if (head_turn != TURN_NOP) begin
            face_nxt  = head_face;
            steps_nxt = turn_steps(head_turn);
            dir_nxt   = (dir_out & ~head_oh) | (turn_is_cw(head_turn) ? head_oh : '0);
            start_nxt = head_oh;
            state_nxt = S_ISSUE;
          end
        end
      end

      // start_out is high during this cycle and falls at its end.
      S_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT_LOW;
      end

      S_WAIT_LOW: begin
        if (!done_sel) begin
          state_nxt = S_WAIT_HIGH;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Driver never acknowledged: flag it and move on after the gap.
          error_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      // No timeout here: long moves are legitimate.
      S_WAIT_HIGH: begin
        if (done_sel) begin
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: scoreboard of expected issues checked by an
// independent monitor, plus directed checks on flags and FIFO occupancy.
module tb_move_sequencer;

  localparam int NM   = 6;
  localparam int QD   = 16;
  localparam int S90  = 50;
  localparam int S180 = 100;
  localparam int ACK  = 4;
  localparam int GAP  = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          move_valid = 1'b0;
  logic          move_ready;
  logic [2:0]    move_face = 3'd0;
  logic [1:0]    move_turn = 2'd0;
  logic [NM-1:0] start_out;
  logic [7:0]    steps_out;
  logic [NM-1:0] dir_out;
  logic [NM-1:0] done_in;
  logic          busy;
  logic [4:0]    queue_count;
  logic          error;

  always #5 clock = ~clock;

  move_sequencer #(
    .NUM_MOTORS (NM),
    .QUEUE_DEPTH(QD),
    .STEPS_90   (S90),
    .STEPS_180  (S180),
    .ACK_TIMEOUT(ACK),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_face  (move_face),
    .move_turn  (move_turn),
    .start_out  (start_out),
    .steps_out  (steps_out),
    .dir_out    (dir_out),
    .done_in    (done_in),
    .busy       (busy),
    .queue_count(queue_count),
    .error      (error)
  );

  // Stepper driver model: drops done on the edge that samples start, raises it
  // move_len cycles later. ignore_mask drivers never react; stall_mask drivers
  // hold done low until released.
  logic [NM-1:0] done_r = '1;
  logic [NM-1:0] ignore_mask = '0;
  logic [NM-1:0] stall_mask = '0;
  int            mv_cnt [NM];
  int            move_len = 60;
  int            cyc = 0;
  int            last_rise_cyc = -1000;

  assign done_in = done_r;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int m = 0; m < NM; m++) begin
      if (start_out[m] && !ignore_mask[m]) begin
        done_r[m] <= 1'b0;
        mv_cnt[m] <= move_len;
      end else if (!done_r[m] && !stall_mask[m]) begin
        if (mv_cnt[m] == 0) begin
          done_r[m]     <= 1'b1;
          last_rise_cyc <= cyc + 1;
        end else begin
          mv_cnt[m] <= mv_cnt[m] - 1;
        end
      end
    end
  end

  typedef struct packed {
    logic [NM-1:0] start;
    logic [7:0]    steps;
    logic [NM-1:0] dir;
  } exp_t;

  exp_t          sb[$];
  logic [NM-1:0] model_dir = '0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            starts_seen = 0;
  int            prev_start_cyc = -1000;
  logic [NM-1:0] prev_start_s = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Expected issue for a command, computed from the command alone.
  task automatic add_exp(input logic [2:0] f, input logic [1:0] t);
    logic [NM-1:0] oh;
    if (int'(f) < NM && t != 2'b00) begin
      oh           = '0;
      oh[f]        = 1'b1;
      model_dir[f] = (t != 2'b11);
      sb.push_back({oh, (t == 2'b10) ? 8'(S180) : 8'(S90), model_dir});
    end
  endtask

  // Monitor: every start pulse pops one expected issue.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (start_out != '0) begin
      starts_seen++;
      chk("start_width", 32'(prev_start_s), 32'd0);
      if (last_rise_cyc > prev_start_cyc)
        chk("gap_after_done", 32'(cyc - last_rise_cyc >= GAP + 2), 32'd1);
      prev_start_cyc = cyc;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_start: actual start_out=%b required none", start_out);
      end else begin
        e = sb.pop_front();
        chk("issue_start", 32'(start_out), 32'(e.start));
        chk("issue_steps", 32'(steps_out), 32'(e.steps));
        chk("issue_dir",   32'(dir_out),   32'(e.dir));
      end
    end
    prev_start_s = start_out;
  end

  task automatic push(input logic [2:0] f, input logic [1:0] t);
    int w;
    w = 0;
    @(negedge clock);
    while (!move_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (!move_ready) begin
      fail_bound("push_ready");
    end else begin
      move_valid = 1'b1;
      move_face  = f;
      move_turn  = t;
      add_exp(f, t);
      @(posedge clock);
      #1;
      move_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    @(negedge clock);
    while ((busy || sb.size() != 0 || done_in != '1) && w < budget) begin
      @(negedge clock);
      w++;
    end
    if (w >= budget) fail_bound("wait_idle");
    chk("all_issues_seen", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    move_valid = 1'b0;
    sb.delete();
    model_dir  = '0;
    @(negedge clock);
    chk("ready_in_reset", 32'(move_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int w;
    int s0;
    int accepted;
    logic rdy;

    // Reset values
    repeat (2) @(negedge clock);
    chk("ready_in_reset", 32'(move_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_start", 32'(start_out), 32'd0);
    chk("rst_steps", 32'(steps_out), 32'd0);
    chk("rst_dir", 32'(dir_out), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_qcount", 32'(queue_count), 32'd0);
    chk("rst_ready", 32'(move_ready), 32'd1);

    // Single move with latency check, then a second move after a 60-cycle driver
    move_len = 60;
    push(3'd2, 2'b01);
    chk("single_qcount", 32'(queue_count), 32'd1);
    @(negedge clock);
    chk("single_no_early_start", 32'(start_out), 32'd0);
    @(negedge clock);
    chk("single_start", 32'(start_out), 32'b000100);
    chk("single_steps", 32'(steps_out), 32'd50);
    chk("single_dir2", 32'(dir_out[2]), 32'd1);
    push(3'd5, 2'b01);
    wait_idle(400);

    // Mixed turns on one face
    move_len = 10;
    push(3'd0, 2'b11);
    push(3'd0, 2'b10);
    wait_idle(300);
    chk("mixed_dir_final", 32'(dir_out), 32'b100101);
    chk("mixed_steps_final", 32'(steps_out), 32'd100);

    // No-op and illegal entries
    s0 = starts_seen;
    push(3'd1, 2'b00);
    wait_idle(50);
    chk("noop_error", 32'(error), 32'd0);
    push(3'd7, 2'b01);
    wait_idle(50);
    chk("illegal_error", 32'(error), 32'd1);
    push(3'd1, 2'b00);
    wait_idle(50);
    chk("noop_error_sticky", 32'(error), 32'd1);
    chk("dropped_no_start", 32'(starts_seen), 32'(s0));
    chk("dir_hold", 32'(dir_out), 32'b100101);
    do_reset();
    chk("reset_clears_error", 32'(error), 32'd0);
    chk("reset_clears_dir", 32'(dir_out), 32'd0);

    // Acknowledge timeout: motor 4 never drops done
    ignore_mask = 6'b010000;
    move_len    = 5;
    push(3'd4, 2'b01);
    push(3'd5, 2'b11);
    w = 0;
    while (!start_out[4] && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (!start_out[4]) fail_bound("timeout_start");
    n = 0;
    while (!error && n < 12) begin
      @(negedge clock);
      n++;
    end
    chk("ack_timeout_latency", 32'(n >= 5 && n <= 6), 32'd1);
    wait_idle(200);
    chk("timeout_error", 32'(error), 32'd1);
    ignore_mask = '0;
    do_reset();

    // Full FIFO with the driver stalled
    stall_mask = 6'b000010;
    move_len   = 2;
    accepted   = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      move_valid = 1'b1;
      move_face  = 3'd1;
      move_turn  = 2'b01;
      rdy        = move_ready;
      if (rdy) add_exp(3'd1, 2'b01);
      @(posedge clock);
      #1;
      if (rdy) accepted++;
    end
    move_valid = 1'b0;
    chk("full_accepted", 32'(accepted), 32'd17);
    @(negedge clock);
    chk("full_qcount", 32'(queue_count), 32'd16);
    chk("full_ready", 32'(move_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    stall_mask = '0;
    w = 0;
    while (queue_count != 5'd15 && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (queue_count != 5'd15) fail_bound("full_first_pop");
    chk("ready_after_pop", 32'(move_ready), 32'd1);
    wait_idle(1000);
    chk("drained_qcount", 32'(queue_count), 32'd0);

    // Reset in the middle of a move with three entries queued
    stall_mask = 6'b001000;
    move_len   = 3;
    repeat (4) push(3'd3, 2'b01);
    w = 0;
    while (done_in[3] && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (done_in[3]) fail_bound("midmove_ack");
    repeat (3) @(negedge clock);
    chk("midmove_qcount", 32'(queue_count), 32'd3);
    reset = 1'b1;
    sb.delete();
    model_dir = '0;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_qcount", 32'(queue_count), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_start", 32'(start_out), 32'd0);
    s0 = starts_seen;
    stall_mask = '0;
    repeat (30) @(negedge clock);
    chk("midreset_no_new_start", 32'(starts_seen), 32'(s0));
    chk("midreset_driver_finished", 32'(done_in[3]), 32'd1);
    chk("midreset_still_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
